// File: rtl/modulo_demux1_4_seq_pkg.sv
// Shared slot indices for the 4:1 select path and its 1:4 receiving demux.
package modulo_demux1_4_seq_pkg;

    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [SLOT_W-1:0] SLOT_A    = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_B    = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_C    = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_D    = 2'd3;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_D;

    // One-hot decode of a slot index.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        slot_onehot = NUM_SLOTS'(1) << idx;
    endfunction

endpackage

// File: rtl/modulo_slot_counter.sv
// Mod-4 slot counter: sync reset, sync clear (frame marker) and enable (valid word).
// A clear together with enable counts the word as slot A, leaving the count at 1.
module modulo_slot_counter
    import modulo_demux1_4_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [SLOT_W-1:0] count,
    output logic              last_c
);

    // Count register; wraps 3 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= SLOT_A;
        end else if (clr) begin
            count <= en ? SLOT_B : SLOT_A;
        end else if (en) begin
            count <= count + SLOT_W'(1);
        end
    end

    assign last_c = (count == SLOT_LAST);

endmodule

// File: rtl/modulo_demux1_4_seq.sv
// Sequential 1:4 demux: steers a slot-multiplexed word stream into shadow
// registers and publishes all four slots together when a frame completes.
// Optional feature macro: DEMUX_SLOT_STROBE_EN (adds one-hot slot_strobe output).
module modulo_demux1_4_seq
    import modulo_demux1_4_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    input  logic              sync,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic [SLOT_W-1:0] slot_sel,
`ifdef DEMUX_SLOT_STROBE_EN
    output logic [NUM_SLOTS-1:0] slot_strobe,
`endif
    output logic              frame_done,
    output logic              frame_err
);

    // Slot D needs no shadow: the last word goes straight to out_d.
    logic [DATA_W-1:0] shadow_a;
    logic [DATA_W-1:0] shadow_b;
    logic [DATA_W-1:0] shadow_c;
    logic              last_c;
    logic              complete_c;
    logic              discard_c;
    logic [SLOT_W-1:0] wr_slot_c;

    modulo_slot_counter u_slot_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (sync),
        .en     (in_valid),
        .count  (slot_sel),
        .last_c (last_c)
    );

    // Frame events and write target; sync preempts completion.
    always_comb begin
        complete_c = 1'b0;
        discard_c  = 1'b0;
        wr_slot_c  = slot_sel;
        if (sync) begin
            discard_c = (slot_sel != SLOT_A);
            wr_slot_c = SLOT_A;
        end else begin
            complete_c = in_valid && last_c;
        end
    end

    // Shadow capture of accepted words.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
        end else if (in_valid) begin
            case (wr_slot_c)
                SLOT_A:  shadow_a <= data_in;
                SLOT_B:  shadow_b <= data_in;
                SLOT_C:  shadow_c <= data_in;
                default: ;
            endcase
        end
    end

    // Publish outputs and frame status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_a      <= '0;
            out_b      <= '0;
            out_c      <= '0;
            out_d      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= complete_c;
            frame_err  <= discard_c;
            if (complete_c) begin
                out_a <= shadow_a;
                out_b <= shadow_b;
                out_c <= shadow_c;
                out_d <= data_in;
            end
        end
    end

`ifdef DEMUX_SLOT_STROBE_EN
    // One-hot strobe of the slot written on the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_strobe <= '0;
        end else begin
            slot_strobe <= in_valid ? slot_onehot(wr_slot_c) : '0;
        end
    end
`endif

endmodule
